// File: rtl/pll_rst_pkg.sv
// Shared state encoding and sizing helpers for the PLL reset sequencer.
// Pure declarations; no logic, no latency, no flow control.
package pll_rst_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    HOLD_RST  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer, async active-low reset to 0.
// Latency STAGES clk edges; no flow control.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_controller.sv
// PLL reset sequencer: pulse pll_rst, wait for lock, qualify it, then release sys_rst_n.
// Outputs registered from next state (1 refclk of latency); no flow control.
module pll_reset_controller
  import pll_rst_pkg::*;
#(
  parameter int  RST_HOLD_CYCLES    = 16,
  parameter int  LOCK_TIMEOUT       = 50000,
  parameter int  LOCK_STABLE_CYCLES = 1024,
  parameter int  MAX_RETRIES        = 3,
  parameter int  SYNC_STAGES        = 2,
  localparam int RW                 = $clog2(MAX_RETRIES + 1)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  input  logic          force_relock,
  output logic          pll_rst,
  output logic          sys_rst_n,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    relock_count
);

  localparam int TMAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] HOLD_LAST   = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  logic locked_s;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (refclk),
    .rst_n(rst),
    .d    (pll_locked),
    .q    (locked_s)
  );

  state_e          state_q,     state_d;
  logic [TW-1:0]   timer_q,     timer_d;
  logic [RW-1:0]   retry_q,     retry_d;
  logic [7:0]      relock_q,    relock_d;
  logic            pll_rst_q,   pll_rst_d;
  logic            sys_rst_n_q, sys_rst_n_d;
  logic            ready_q,     ready_d;
  logic            fault_q,     fault_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    relock_d = relock_q;

    if (force_relock) begin
      state_d = HOLD_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        HOLD_RST: begin
          if (timer_q == HOLD_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (timer_q == WAIT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = HOLD_RST;
              retry_d = retry_q + RW'(1);
            end
          end
        end
        STABLE: begin
          // A lost lock here just restarts the lock wait; the retry budget is untouched.
          if (!locked_s)                    state_d = WAIT_LOCK;
          else if (timer_q == STABLE_LAST)  state_d = RUN;
        end
        RUN: begin
          if (!locked_s) begin
            state_d = HOLD_RST;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = HOLD_RST;
      endcase
    end

    if (state_d == RUN) retry_d = '0;

    // Timer only runs in the timed states, so it can never wrap.
    if (force_relock || (state_d != state_q)) begin
      timer_d = '0;
    end else if ((state_q == HOLD_RST) || (state_q == WAIT_LOCK) || (state_q == STABLE)) begin
      timer_d = timer_q + TW'(1);
    end

    pll_rst_d   = (state_d == HOLD_RST) || (state_d == FAULT);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q     <= HOLD_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst_n    = sys_rst_n_q;
  assign ready        = ready_q;
  assign fault        = fault_q;
  assign retry_cnt    = retry_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_controller.sv
// Directed bench for pll_reset_controller with small timing parameters.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_pll_reset_controller;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] relock_count;

  int total = 0;
  int bad = 0;

  always #5 refclk = ~refclk;

  pll_reset_controller #(
    .RST_HOLD_CYCLES   (4),
    .LOCK_TIMEOUT      (20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES       (2),
    .SYNC_STAGES       (2)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .relock_count(relock_count)
  );

  // Leaves rst released at a negedge: HOLD_RST with timer 0, pll_rst falls 4 edges later.
  task automatic do_reset();
    rst = 1'b0;
    pll_locked = 1'b0;
    force_relock = 1'b0;
    repeat (2) @(negedge refclk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    rst = 1'b0;
    repeat (3) @(negedge refclk);
    obs = {pll_rst, sys_rst_n, ready, fault, retry_cnt, relock_count};
    total++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset_values: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0});
    end
  endtask

  task automatic test_lock_up();
    int hi;
    int cnt;
    do_reset();
    hi = 0;
    while (pll_rst === 1'b1 && hi < 20) begin
      hi++;
      @(negedge refclk);
    end
    total++;
    if (hi !== 4) begin bad++; $display("FAIL lockup_pll_rst_len: got %0d want 4", hi); end
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    cnt = 0;
    do begin
      @(negedge refclk);
      cnt++;
    end while (sys_rst_n !== 1'b1 && cnt < 40);
    total++;
    if (cnt !== 11) begin bad++; $display("FAIL lockup_release_delay: got %0d want 11", cnt); end
    total++;
    if ({ready, pll_rst, fault, retry_cnt} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL lockup_run_outputs: got %b want %b", {ready, pll_rst, fault, retry_cnt}, 5'b10000);
    end
  endtask

  task automatic test_timeout_fault();
    int hi;
    int lo;
    logic [1:0] rc;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      hi = 0;
      rc = 2'bxx;
      while (pll_rst === 1'b1 && hi < 50) begin
        rc = retry_cnt;
        hi++;
        @(negedge refclk);
      end
      total++;
      if (hi !== 4) begin bad++; $display("FAIL timeout_pulse%0d_len: got %0d want 4", p, hi); end
      total++;
      if (rc !== 2'(p)) begin bad++; $display("FAIL timeout_pulse%0d_retry: got %0d want %0d", p, rc, p); end
      lo = 0;
      while (pll_rst === 1'b0 && fault === 1'b0 && lo < 100) begin
        lo++;
        @(negedge refclk);
      end
      total++;
      if (lo !== 20) begin bad++; $display("FAIL timeout_wait%0d_len: got %0d want 20", p, lo); end
    end
    repeat (5) @(negedge refclk);
    total++;
    if ({fault, pll_rst, sys_rst_n, ready} !== 4'b1100) begin
      bad++;
      $display("FAIL fault_outputs: got %b want 1100", {fault, pll_rst, sys_rst_n, ready});
    end
    force_relock = 1'b1;
    @(negedge refclk);
    force_relock = 1'b0;
    total++;
    if ({fault, retry_cnt, pll_rst} !== {1'b0, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL fault_force_exit: got %b want 0001", {fault, retry_cnt, pll_rst});
    end
    hi = 0;
    while (pll_rst === 1'b1 && hi < 20) begin
      hi++;
      @(negedge refclk);
    end
    total++;
    if (hi !== 4) begin bad++; $display("FAIL fault_repulse_len: got %0d want 4", hi); end
  endtask

  task automatic test_stable_glitch();
    int cnt;
    logic seen_rel;
    do_reset();
    repeat (7) @(negedge refclk);
    pll_locked = 1'b1;
    // locked_s reaches STABLE at edge 10; this drop makes locked_s low while the timer reads 5.
    repeat (6) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    cnt = 0;
    seen_rel = 1'b0;
    do begin
      @(negedge refclk);
      cnt++;
      if (sys_rst_n === 1'b1) seen_rel = 1'b1;
    end while (!seen_rel && cnt < 40);
    total++;
    if (cnt !== 11) begin bad++; $display("FAIL glitch_release_delay: got %0d want 11", cnt); end
    total++;
    if ({ready, retry_cnt, relock_count} !== {1'b1, 2'd0, 8'd0}) begin
      bad++;
      $display("FAIL glitch_run_state: got %b want %b", {ready, retry_cnt, relock_count}, {1'b1, 2'd0, 8'd0});
    end
  endtask

  task automatic test_run_loss();
    int exp_cnt;
    int w;
    exp_cnt = 0;
    for (int i = 0; i < 261; i++) begin
      if (i > 0) begin
        pll_locked = 1'b1;
        w = 0;
        while (ready !== 1'b1 && w < 60) begin
          w++;
          @(negedge refclk);
        end
        if (w >= 60) begin
          total++;
          bad++;
          $display("FAIL run_loss_relock_timeout: iter %0d ready=%b", i, ready);
        end
      end
      pll_locked = 1'b0;
      repeat (3) @(negedge refclk);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (i == 0) begin
        total++;
        if ({sys_rst_n, ready, pll_rst} !== 3'b001) begin
          bad++;
          $display("FAIL run_loss_outputs: got %b want 001", {sys_rst_n, ready, pll_rst});
        end
      end
      total++;
      if (relock_count !== 8'(exp_cnt)) begin
        bad++;
        $display("FAIL run_loss_count iter %0d: got %0d want %0d", i, relock_count, exp_cnt);
      end
    end
  endtask

  task automatic test_force_on_loss();
    int w;
    int hi;
    do_reset();
    repeat (7) @(negedge refclk);
    pll_locked = 1'b1;
    w = 0;
    while (ready !== 1'b1 && w < 40) begin
      w++;
      @(negedge refclk);
    end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL force_loss_reach_run: got ready=%b want 1", ready); end
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    force_relock = 1'b1;
    @(negedge refclk);
    force_relock = 1'b0;
    total++;
    if ({pll_rst, sys_rst_n, ready, retry_cnt, relock_count} !== {1'b1, 1'b0, 1'b0, 2'd0, 8'd0}) begin
      bad++;
      $display("FAIL force_loss_state: got %b want %b", {pll_rst, sys_rst_n, ready, retry_cnt, relock_count},
               {1'b1, 1'b0, 1'b0, 2'd0, 8'd0});
    end
    hi = 0;
    while (pll_rst === 1'b1 && hi < 20) begin
      hi++;
      @(negedge refclk);
    end
    total++;
    if (hi !== 4) begin bad++; $display("FAIL force_loss_pulse_len: got %0d want 4", hi); end
  endtask

  task automatic test_async_reset();
    logic [13:0] obs;
    int hi;
    do_reset();
    // 4 hold + 20 wait + 4 hold puts us 2 cycles into the second WAIT_LOCK with one retry spent.
    repeat (30) @(negedge refclk);
    total++;
    if ({pll_rst, retry_cnt} !== {1'b0, 2'd1}) begin
      bad++;
      $display("FAIL async_precondition: got %b want 001", {pll_rst, retry_cnt});
    end
    #2;
    rst = 1'b0;
    #1;
    obs = {pll_rst, sys_rst_n, ready, fault, retry_cnt, relock_count};
    total++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}) begin
      bad++;
      $display("FAIL async_reset_values: got %b want %b", obs, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0});
    end
    @(negedge refclk);
    rst = 1'b1;
    hi = 0;
    while (pll_rst === 1'b1 && hi < 20) begin
      hi++;
      @(negedge refclk);
    end
    total++;
    if (hi !== 4) begin bad++; $display("FAIL async_repulse_len: got %0d want 4", hi); end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_timeout_fault();
    test_stable_glitch();
    test_run_loss();
    test_force_on_loss();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
